// File: rtl/cache_types_pkg.sv
// Shared types and field widths for the direct-mapped write-back L1 cache controller.
package cache_types_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  localparam int TAG_W      = 24;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 5;
  localparam int LINE_BYTES = 32;

  localparam logic FILL_CPU = 1'b0;
  localparam logic FILL_MEM = 1'b1;

endpackage

// File: rtl/cache_meta.sv
// Per-set valid/dirty/tag storage with combinational read and independent tag and dirty writes.
module cache_meta
  import cache_types_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             tag_we_i,
  input  logic [TAG_W-1:0] tag_wdata_i,
  input  logic             dirty_we_i,
  input  logic             dirty_wdata_i,
  output logic             valid_o,
  output logic             dirty_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             valid_q [NUM_SETS];
  logic             dirty_q [NUM_SETS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS];
  logic [NUM_SETS-1:0] tag_sel;
  logic [NUM_SETS-1:0] dirty_sel;

  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_sel
    assign tag_sel[gi]   = tag_we_i   && (idx_i == IDX_W'(gi));
    assign dirty_sel[gi] = dirty_we_i && (idx_i == IDX_W'(gi));
  end

  // A tag write also marks the entry valid; dirty is written separately.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SETS; i++) begin
      if (!rst) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
      end else begin
        if (tag_sel[i]) begin
          tag_q[i]   <= tag_wdata_i;
          valid_q[i] <= 1'b1;
        end
        if (dirty_sel[i]) begin
          dirty_q[i] <= dirty_wdata_i;
        end
      end
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// Control FSM for the direct-mapped write-back L1: hit handling, dirty-victim writeback, line allocation.
module cache_ctrl
  import cache_types_pkg::*;
#(
  parameter int block_size = 256,
  parameter int num_sets   = 8,
  parameter int ctr_width  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             cpu_addr,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [3:0]              cpu_wmask,
  output logic                    cpu_resp,
  output logic                    da_load,
  output logic [IDX_W-1:0]        da_rd_addr,
  output logic [IDX_W-1:0]        da_wr_addr,
  output logic                    da_fill_sel,
  output logic [block_size/8-1:0] da_byte_en,
  output logic [31:0]             mem_addr,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic                    mem_resp,
  output logic [ctr_width-1:0]    hit_count,
  output logic [ctr_width-1:0]    miss_count
);

  state_e state_q, state_d;
  logic   refill_q, refill_d;
  logic [ctr_width-1:0] hit_q, miss_q;

  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] idx;
  logic [2:0]       word;
  logic             meta_valid, meta_dirty;
  logic [TAG_W-1:0] meta_tag;
  logic             hit;
  logic             tag_we, dirty_we, dirty_wdata;
  logic             hit_inc, miss_inc;
  logic             unused_addr_bits;

  assign cpu_tag          = cpu_addr[31:32-TAG_W];
  assign idx              = cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign word             = cpu_addr[4:2];
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign da_rd_addr       = idx;
  assign da_wr_addr       = idx;
  assign hit              = meta_valid && (meta_tag == cpu_tag);
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

  cache_meta #(.NUM_SETS(num_sets)) u_meta (
    .clk           (clk),
    .rst           (rst),
    .idx_i         (idx),
    .tag_we_i      (tag_we),
    .tag_wdata_i   (cpu_tag),
    .dirty_we_i    (dirty_we),
    .dirty_wdata_i (dirty_wdata),
    .valid_o       (meta_valid),
    .dirty_o       (meta_dirty),
    .tag_o         (meta_tag)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      if (hit_inc)  hit_q  <= hit_q + 1'b1;
      if (miss_inc) miss_q <= miss_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    refill_d    = refill_q;
    cpu_resp    = 1'b0;
    da_load     = 1'b0;
    da_fill_sel = FILL_CPU;
    da_byte_en  = '0;
    mem_addr    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    tag_we      = 1'b0;
    dirty_we    = 1'b0;
    dirty_wdata = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        refill_d = 1'b0;
        if (cpu_read || cpu_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          // The compare that follows a refill was already counted as a miss.
          cpu_resp = 1'b1;
          hit_inc  = !refill_q;
          refill_d = 1'b0;
          state_d  = IDLE;
          if (cpu_write) begin
            da_load     = 1'b1;
            da_byte_en  = (block_size/8)'(cpu_wmask) << {word, 2'b00};
            dirty_we    = 1'b1;
            dirty_wdata = 1'b1;
          end
        end else begin
          miss_inc = 1'b1;
          state_d  = (meta_valid && meta_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {meta_tag, idx, {OFF_W{1'b0}}};
        if (mem_resp) begin
          dirty_we = 1'b1;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {cpu_tag, idx, {OFF_W{1'b0}}};
        if (mem_resp) begin
          da_load     = 1'b1;
          da_fill_sel = FILL_MEM;
          da_byte_en  = '1;
          tag_we      = 1'b1;
          dirty_we    = 1'b1;
          refill_d    = 1'b1;
          state_d     = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl; a second instance with 4-bit counters exercises counter wrap.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_read, cpu_write;
  logic [3:0]  cpu_wmask;
  logic        mem_resp;

  logic        cpu_resp, da_load, da_fill_sel, mem_read, mem_write;
  logic [2:0]  da_rd_addr, da_wr_addr;
  logic [31:0] da_byte_en, mem_addr;
  logic [15:0] hit_count, miss_count;

  logic        w_cpu_resp, w_da_load, w_da_fill_sel, w_mem_read, w_mem_write;
  logic [2:0]  w_da_rd_addr, w_da_wr_addr;
  logic [31:0] w_da_byte_en, w_mem_addr;
  logic [3:0]  w_hit_count, w_miss_count;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wmask(cpu_wmask), .cpu_resp(cpu_resp), .da_load(da_load), .da_rd_addr(da_rd_addr),
    .da_wr_addr(da_wr_addr), .da_fill_sel(da_fill_sel), .da_byte_en(da_byte_en),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_ctrl #(.ctr_width(4)) dut_w (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wmask(cpu_wmask), .cpu_resp(w_cpu_resp), .da_load(w_da_load), .da_rd_addr(w_da_rd_addr),
    .da_wr_addr(w_da_wr_addr), .da_fill_sel(w_da_fill_sel), .da_byte_en(w_da_byte_en),
    .mem_addr(w_mem_addr), .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_resp(mem_resp),
    .hit_count(w_hit_count), .miss_count(w_miss_count)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrs(input string tag);
    chk({tag, "_hit"},    64'(hit_count),    64'(exp_hit[15:0]));
    chk({tag, "_miss"},   64'(miss_count),   64'(exp_miss[15:0]));
    chk({tag, "_w_hit"},  64'(w_hit_count),  64'(exp_hit[3:0]));
    chk({tag, "_w_miss"}, 64'(w_miss_count), 64'(exp_miss[3:0]));
  endtask

  // Request that must hit: response in the COMPARE cycle right after IDLE.
  task automatic hit_access(input string tag, input logic [31:0] addr, input logic rd,
                            input logic wr, input logic [3:0] mask, input logic [31:0] exp_be);
    cpu_addr = addr; cpu_read = rd; cpu_write = wr; cpu_wmask = mask;
    #1;
    chk({tag, "_idle_resp"}, 64'(cpu_resp), 64'(0));
    tick();
    #1;
    chk({tag, "_resp"},    64'(cpu_resp), 64'(1));
    chk({tag, "_memrd"},   64'(mem_read), 64'(0));
    chk({tag, "_load"},    64'(da_load),  64'(wr));
    chk({tag, "_byte_en"}, 64'(da_byte_en), 64'(exp_be));
    tick();
    cpu_read = 1'b0; cpu_write = 1'b0;
    exp_hit++;
    #1;
    chk_ctrs(tag);
  endtask

  initial begin
    rst = 1'b0; cpu_addr = 32'h0000_00E0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_wmask = 4'h0; mem_resp = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_rd_addr", 64'(da_rd_addr), 64'(7));
    chk("rst_wr_addr", 64'(da_wr_addr), 64'(7));
    chk("rst_outs", 64'({cpu_resp, da_load, da_fill_sel, mem_read, mem_write}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk_ctrs("rst");
    rst = 1'b1;
    tick();

    // Cold read 0x1020: clean miss, memory answers after several ALLOCATE cycles.
    cpu_addr = 32'h0000_1020; cpu_read = 1'b1;
    #1 chk("cold_idle_resp", 64'(cpu_resp), 64'(0));
    tick();
    #1 chk("cold_cmp_memrd", 64'(mem_read), 64'(0));
    chk("cold_cmp_resp", 64'(cpu_resp), 64'(0));
    tick();
    exp_miss++;
    #1 chk("cold_alloc_memrd", 64'(mem_read), 64'(1));
    chk("cold_alloc_memwr", 64'(mem_write), 64'(0));
    chk("cold_alloc_addr", 64'(mem_addr), 64'(32'h0000_1020));
    chk_ctrs("cold_alloc");
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk("cold_alloc_hold", 64'(mem_read), 64'(1));
    end
    mem_resp = 1'b1;
    #1 chk("cold_fill_load", 64'(da_load), 64'(1));
    chk("cold_fill_sel", 64'(da_fill_sel), 64'(1));
    chk("cold_fill_be", 64'(da_byte_en), 64'(32'hFFFF_FFFF));
    tick();
    mem_resp = 1'b0;
    #1 chk("cold_recmp_resp", 64'(cpu_resp), 64'(1));
    chk("cold_recmp_load", 64'(da_load), 64'(0));
    tick();
    cpu_read = 1'b0;
    #1 chk_ctrs("cold_done");

    hit_access("rd_hit", 32'h0000_1024, 1'b1, 1'b0, 4'h0, 32'h0);
    hit_access("wr_hit", 32'h0000_1028, 1'b0, 1'b1, 4'b0011, 32'h0000_0300);

    // Same index, new tag: the dirty 0x1020 line must be written back first.
    cpu_addr = 32'h0000_2020; cpu_read = 1'b1;
    tick();
    #1 chk("dm_cmp_resp", 64'(cpu_resp), 64'(0));
    tick();
    exp_miss++;
    #1 chk("dm_wb_memwr", 64'(mem_write), 64'(1));
    chk("dm_wb_memrd", 64'(mem_read), 64'(0));
    chk("dm_wb_addr", 64'(mem_addr), 64'(32'h0000_1020));
    chk_ctrs("dm_wb");
    tick();
    #1 chk("dm_wb_hold", 64'(mem_write), 64'(1));
    mem_resp = 1'b1;
    #1 chk("dm_wb_noload", 64'(da_load), 64'(0));
    tick();
    mem_resp = 1'b0;
    #1 chk("dm_alloc_memrd", 64'(mem_read), 64'(1));
    chk("dm_alloc_memwr", 64'(mem_write), 64'(0));
    chk("dm_alloc_addr", 64'(mem_addr), 64'(32'h0000_2020));
    mem_resp = 1'b1;
    #1 chk("dm_fill_load", 64'(da_load), 64'(1));
    tick();
    mem_resp = 1'b0;
    #1 chk("dm_recmp_resp", 64'(cpu_resp), 64'(1));
    tick();
    cpu_read = 1'b0;
    #1 chk_ctrs("dm_done");

    // Reset while ALLOCATE waits for memory (victim 0x2020 is clean).
    cpu_addr = 32'h0000_3020; cpu_read = 1'b1;
    tick();
    tick();
    #1 chk("rsta_memrd", 64'(mem_read), 64'(1));
    chk("rsta_memwr", 64'(mem_write), 64'(0));
    chk("rsta_addr", 64'(mem_addr), 64'(32'h0000_3020));
    rst = 1'b0; cpu_read = 1'b0;
    tick();
    exp_hit = 0; exp_miss = 0;
    #1 chk("rsta_after_memrd", 64'(mem_read), 64'(0));
    chk_ctrs("rsta_after");
    rst = 1'b1;

    // Valid bits were cleared, so 0x2020 misses cleanly again.
    cpu_addr = 32'h0000_2020; cpu_read = 1'b1;
    tick();
    #1 chk("rm_cmp_resp", 64'(cpu_resp), 64'(0));
    tick();
    exp_miss++;
    #1 chk("rm_alloc_memrd", 64'(mem_read), 64'(1));
    chk("rm_alloc_memwr", 64'(mem_write), 64'(0));
    chk("rm_alloc_addr", 64'(mem_addr), 64'(32'h0000_2020));
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    #1 chk("rm_recmp_resp", 64'(cpu_resp), 64'(1));
    tick();
    cpu_read = 1'b0;
    #1 chk_ctrs("rm_done");

    // Stray memory response in IDLE.
    mem_resp = 1'b1;
    #1 chk("stray_load", 64'(da_load), 64'(0));
    chk("stray_memrd", 64'(mem_read), 64'(0));
    tick();
    mem_resp = 1'b0;
    #1 chk("stray_after", 64'({cpu_resp, mem_read, mem_write, da_load}), 64'(0));
    hit_access("stray_hit", 32'h0000_2024, 1'b1, 1'b0, 4'h0, 32'h0);

    // Read and write together behave as a write; top word lane.
    hit_access("rw_hit", 32'h0000_203C, 1'b1, 1'b1, 4'b1000, 32'h8000_0000);

    // Enough hits to wrap the 4-bit counters of dut_w.
    for (int i = 0; i < 20; i++) begin
      hit_access("loop_hit", 32'h0000_2020 + 32'(i % 8) * 4, 1'b1, 1'b0, 4'h0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
